uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rstb.
REQ-002 clk  input  1  system clock, 100 MHz, rising edge.
REQ-003 rstb  input  1  asynchronous active-low reset.
REQ-004 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 baud_select  input  4  baud index, same encoding as the transmit-side baud generator.
REQ-006 parity_en  input  1  1 = a parity bit follows the data bits.
REQ-007 parity_odd  input  1  1 = odd parity, 0 = even; ignored when parity_en=0.
REQ-008 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-009 rx_data  output  8  received byte, LSB first on the line.
REQ-010 rx_valid  output  1  rx_data and its error flags are held stable.
REQ-011 parity_err  output  1  parity mismatch for the byte held in rx_data.
REQ-012 frame_err  output  1  stop bit sampled low for the byte held in rx_data.
REQ-013 overrun  output  1  one-clk pulse: a completed frame was dropped.
REQ-014 busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; both flops reset to 1.
REQ-016 A 16x oversample tick SHALL be generated from a divisor table indexed by baud_select: 0..11 = 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600 baud, with divisors 20833, 5208, 2604, 1302, 651, 326, 163, 109, 54, 27, 14, 7.
REQ-017 baud_select values 12..15 SHALL behave as 11.
REQ-018 baud_select, parity_en and parity_odd SHALL be latched at start detection; changes mid-frame have no effect.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-020 IDLE->START SHALL occur on a synchronized falling edge of rx; the tick divider restarts at that edge to align phase.
REQ-021 Each bit SHALL be decided by a 2-of-3 majority vote of the samples at ticks 7, 8 and 9 of that bit's 16-tick period.
REQ-022 In START, a vote of 1 SHALL be treated as a false start: return to IDLE with no output change.
REQ-023 DATA SHALL capture 8 bits, LSB first.
REQ-024 After DATA, the FSM SHALL enter PARITY if parity_en=1, otherwise STOP.
REQ-025 The parity error condition SHALL be (XOR of data ^ parity bit) != parity_odd.
REQ-026 In STOP, a vote of 0 SHALL set frame error; the FSM then enters WAIT_IDLE and stays there until the synchronized rx is 1 (break handling), otherwise it goes to IDLE.
REQ-027 rx_data, parity_err, frame_err and rx_valid SHALL update one clk after the stop-bit tick-9 sample.
REQ-028 The byte SHALL be delivered even when it carries errors.
REQ-029 rx_valid SHALL stay high until a clk edge with rx_valid && rx_ready; rx_valid clears on that edge.
REQ-030 If a frame completes while rx_valid=1 and rx_ready=0, the new frame SHALL be discarded, the old data retained, and overrun pulsed for 1 clk.
REQ-031 A frame completing on the same edge that the held byte is accepted SHALL be loaded, with no overrun.
REQ-032 The receiver SHALL accept a new start bit immediately after STOP with no idle gap.

Reset
REQ-033 Assertion of rstb at any time, including mid-frame, SHALL asynchronously force: FSM=IDLE, rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0, all counters=0.
REQ-034 After rstb deasserts, a frame already in progress on the line SHALL be ignored until a fresh falling edge is detected.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the divisor table, the 16x oversample constant and the data width (8).
REQ-036 The tick divider SHALL be a separate sub-module, uart_rx_baud_tick, with ports clk, rstb, baud_select, restart and tick.
REQ-037 The FSM and data path SHALL remain in uart_receiver.

Verification
REQ-038 Byte 0xA5 at baud_select=11, no parity -> rx_valid rises with rx_data=0xA5 and both error flags 0.
REQ-039 Byte 0x3C with parity_en=1, parity_odd=0 and a wrong parity bit -> rx_data=0x3C, parity_err=1; the same byte with correct parity -> parity_err=0.
REQ-040 A 40-clk low glitch at baud_select=11 -> no rx_valid, busy returns low, FSM back in IDLE.
REQ-041 Stop bit driven low, then line held low for 30 bit periods -> one byte with frame_err=1 and no further frames until rx returns high.
REQ-042 Two back-to-back frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11 and overrun pulses once; raise rx_ready -> rx_valid clears after one accept.
REQ-043 rstb asserted mid-DATA of 0x55, released, then 0x66 sent -> only 0x66 is delivered, with outputs at reset values in between.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path.
package uart_receiver_pkg;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  // 16x oversample divisors of the 100 MHz clock; indices above 11 reuse 921600 baud.
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [3:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      4'd0:    div = 15'd20833;
      4'd1:    div = 15'd5208;
      4'd2:    div = 15'd2604;
      4'd3:    div = 15'd1302;
      4'd4:    div = 15'd651;
      4'd5:    div = 15'd326;
      4'd6:    div = 15'd163;
      4'd7:    div = 15'd109;
      4'd8:    div = 15'd54;
      4'd9:    div = 15'd27;
      4'd10:   div = 15'd14;
      default: div = 15'd7;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// 16x oversample tick generator; restart re-phases the divider to the current clk.
module uart_rx_baud_tick
  import uart_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rstb,
  input  logic [3:0] baud_select,
  input  logic       restart,
  output logic       tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= baud_divisor(baud_select) - 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  // First tick lands exactly one divisor period after a restart.
  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: synchronizer, start detection, majority-vote bit FSM, and output hold register.
//
// state        | meaning
// IDLE         | line idle, waiting for a synchronized falling edge
// START        | validating the start bit
// DATA         | shifting in data bits, LSB first
// PARITY       | sampling the parity bit
// STOP         | sampling the stop bit and delivering the frame
// WAIT_IDLE    | stop bit was low (break); wait for the line to go high
module uart_receiver
  import uart_receiver_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              rx,
  input  logic [3:0]        baud_select,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  rx_state_t state, state_next;

  logic              rx_meta, rx_sync, rx_prev;
  logic [1:0]        sync_fill;
  logic              armed;
  logic              fall, start_det;

  logic [3:0]        baud_lat, baud_eff;
  logic              par_en_lat, par_odd_lat;

  logic              tick;
  logic [3:0]        tick_rem;
  logic [1:0]        samp;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_err_q;

  logic              in_frame, sample_en, vote_en, bit_end, vote, frame_done;

  // Edge detection is armed only once the synchronizer carries a real high from
  // the line, so a frame already low at reset release is not taken as a start.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_sync) armed <= 1'b1;
    end
  end

  assign fall      = armed && rx_prev && !rx_sync;
  assign start_det = (state == ST_IDLE) && fall;
  assign baud_eff  = (state == ST_IDLE) ? baud_select : baud_lat;

  uart_rx_baud_tick u_tick (
    .clk         (clk),
    .rstb        (rstb),
    .baud_select (baud_eff),
    .restart     (start_det),
    .tick        (tick)
  );

  // tick_rem counts down the ticks left in the bit; 9/8/7 are ticks 7/8/9 of the bit.
  assign in_frame   = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
  assign sample_en  = tick && in_frame && (tick_rem inside {4'd9, 4'd8, 4'd7});
  assign vote_en    = tick && in_frame && (tick_rem == 4'd7);
  assign bit_end    = tick && in_frame && (tick_rem == 4'd0);
  assign vote       = (samp[1] & samp[0]) | (samp[1] & rx_sync) | (samp[0] & rx_sync);
  assign frame_done = (state == ST_STOP) && vote_en;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (fall) state_next = ST_START;
      end
      ST_START: begin
        if (vote_en && vote) state_next = ST_IDLE;
        else if (bit_end)    state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt == 4'd0)) state_next = par_en_lat ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (vote_en) state_next = vote ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_sync) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      baud_lat    <= '0;
      par_en_lat  <= 1'b0;
      par_odd_lat <= 1'b0;
      tick_rem    <= '0;
      samp        <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par_err_q   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (start_det) begin
        baud_lat    <= baud_select;
        par_en_lat  <= parity_en;
        par_odd_lat <= parity_odd;
        tick_rem    <= 4'(OVERSAMPLE - 1);
        bit_cnt     <= 4'(DATA_W);
        par_err_q   <= 1'b0;
      end else if (tick && in_frame) begin
        tick_rem <= tick_rem - 1'b1;
      end

      if (sample_en) samp <= {samp[0], rx_sync};

      if (vote_en && (state == ST_DATA)) begin
        shift   <= {vote, shift[DATA_W-1:1]};
        bit_cnt <= bit_cnt - 1'b1;
      end

      if (vote_en && (state == ST_PARITY)) begin
        par_err_q <= ((^shift) ^ vote) != par_odd_lat;
      end

      // A frame finishing on the accepting edge replaces the held byte.
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift;
          parity_err <= par_en_lat && par_err_q;
          frame_err  <= !vote;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed vector table, corner sequences, random frames.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rstb;
  logic       rx;
  logic [3:0] baud_select;
  logic       parity_en;
  logic       parity_odd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int ovr_cnt = 0;
  int rise_cnt = 0;
  logic valid_prev = 1'b0;

  uart_receiver dut (
    .clk         (clk),
    .rstb        (rstb),
    .rx          (rx),
    .baud_select (baud_select),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && !valid_prev) rise_cnt <= rise_cnt + 1;
    valid_prev <= rx_valid;
  end

  // Bit period in clocks: 16 ticks of the divisor for that baud index.
  function automatic int bit_clks(input logic [3:0] sel);
    int div_tab [12] = '{20833, 5208, 2604, 1302, 651, 326, 163, 109, 54, 27, 14, 7};
    int idx;
    idx = (sel > 4'd11) ? 11 : int'(sel);
    return 16 * div_tab[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Parity bit follows the usual definition (even: total ones even); bad flips it.
  task automatic drive_frame(input logic [7:0] d, input bit pen, input bit podd, input bit bad,
                             input bit stopv, input int bclk, input int max_bits, input bit scramble);
    logic [10:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pen) begin
      bits[9] = (^d) ^ podd ^ bad;
      n = 10;
    end
    bits[n] = stopv;
    n++;
    for (int i = 0; i < n && i < max_bits; i++) begin
      rx = bits[i];
      if (scramble && i == 1) begin
        baud_select = 4'($urandom);
        parity_en   = 1'($urandom);
        parity_odd  = 1'($urandom);
      end
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(rx_data),    32'h0);
    chk({tag, "_valid"}, 32'(rx_valid),   32'h0);
    chk({tag, "_perr"},  32'(parity_err), 32'h0);
    chk({tag, "_ferr"},  32'(frame_err),  32'h0);
    chk({tag, "_ovr"},   32'(overrun),    32'h0);
    chk({tag, "_busy"},  32'(busy),       32'h0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] baud;
    bit         pen;
    bit         podd;
    bit         bad_par;
    bit         stopv;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int r0, o0, bc;
    bit m_valid, m_perr, m_ferr, exp_ovr;
    logic [7:0] m_data;

    vecs[0] = '{8'hA5, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 4'd11, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'hF0, 4'd13, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 4'd10, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    rstb = 1'b0; rx = 1'b1; baud_select = 4'd11;
    parity_en = 1'b0; parity_odd = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstb = 1'b1;
    repeat (10) @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      baud_select = vecs[v].baud;
      parity_en   = vecs[v].pen;
      parity_odd  = vecs[v].podd;
      drive_frame(vecs[v].data, vecs[v].pen, vecs[v].podd, vecs[v].bad_par, vecs[v].stopv,
                  bit_clks(vecs[v].baud), 11, 1'b0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      chk($sformatf("vec%0d_valid", v), 32'(rx_valid),   32'h1);
      chk($sformatf("vec%0d_data", v),  32'(rx_data),    32'(vecs[v].exp_data));
      chk($sformatf("vec%0d_perr", v),  32'(parity_err), 32'(vecs[v].exp_perr));
      chk($sformatf("vec%0d_ferr", v),  32'(frame_err),  32'(vecs[v].exp_ferr));
      accept();
      chk($sformatf("vec%0d_accept", v), 32'(rx_valid), 32'h0);
      repeat (20) @(negedge clk);
    end

    // Short low glitch is a false start
    baud_select = 4'd11;
    r0 = rise_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_no_valid", 32'(rise_cnt - r0), 32'h0);

    // Break: stop low, then line held low 30 bit periods
    r0 = rise_cnt;
    parity_en = 1'b0;
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, bit_clks(4'd11), 11, 1'b0);
    repeat (30 * bit_clks(4'd11)) @(negedge clk);
    chk("break_frames", 32'(rise_cnt - r0), 32'h1);
    chk("break_data", 32'(rx_data), 32'h5A);
    chk("break_ferr", 32'(frame_err), 32'h1);
    chk("break_busy", 32'(busy), 32'h1);
    accept();
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_idle", 32'(busy), 32'h0);
    chk("break_frames_after", 32'(rise_cnt - r0), 32'h1);

    // Back-to-back frames with consumer stalled
    o0 = ovr_cnt;
    drive_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, bit_clks(4'd11), 11, 1'b0);
    drive_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, bit_clks(4'd11), 11, 1'b0);
    repeat (5) @(negedge clk);
    chk("b2b_data", 32'(rx_data), 32'h11);
    chk("b2b_valid", 32'(rx_valid), 32'h1);
    chk("b2b_overrun", 32'(ovr_cnt - o0), 32'h1);
    accept();
    chk("b2b_accept", 32'(rx_valid), 32'h0);
    repeat (20) @(negedge clk);

    // Reset in the middle of a frame
    r0 = rise_cnt;
    drive_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, bit_clks(4'd11), 5, 1'b0);
    rstb = 1'b0;
    rx = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    rstb = 1'b1;
    repeat (2 * bit_clks(4'd11)) @(negedge clk);
    chk_reset_outputs("postrst");
    drive_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, bit_clks(4'd11), 11, 1'b0);
    repeat (5) @(negedge clk);
    chk("postrst_data", 32'(rx_data), 32'h66);
    chk("postrst_frames", 32'(rise_cnt - r0), 32'h1);
    accept();
    repeat (20) @(negedge clk);

    // Random frames against a transaction-level model of the hold register
    m_valid = 1'b0; m_data = 8'h66; m_perr = 1'b0; m_ferr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      logic [3:0] b;
      bit pen, podd, bad, stopv;
      d     = 8'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? 4'd10 : 4'($urandom_range(11, 15));
      pen   = 1'($urandom);
      podd  = 1'($urandom);
      bad   = ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 5) != 0);
      bc    = bit_clks(b);
      baud_select = b; parity_en = pen; parity_odd = podd;
      o0 = ovr_cnt;
      drive_frame(d, pen, podd, bad, stopv, bc, 11, 1'b1);
      rx = 1'b1;
      repeat ($urandom_range(1, 40)) @(negedge clk);
      if (!m_valid) begin
        m_valid = 1'b1; m_data = d; m_perr = pen && bad; m_ferr = !stopv; exp_ovr = 1'b0;
      end else begin
        exp_ovr = 1'b1;
      end
      chk($sformatf("rnd%0d_valid", k), 32'(rx_valid),     32'(m_valid));
      chk($sformatf("rnd%0d_data", k),  32'(rx_data),      32'(m_data));
      chk($sformatf("rnd%0d_perr", k),  32'(parity_err),   32'(m_perr));
      chk($sformatf("rnd%0d_ferr", k),  32'(frame_err),    32'(m_ferr));
      chk($sformatf("rnd%0d_ovr", k),   32'(ovr_cnt - o0), 32'(exp_ovr));
      if ($urandom_range(0, 2) != 0) begin
        accept();
        m_valid = 1'b0;
        chk($sformatf("rnd%0d_accept", k), 32'(rx_valid), 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
